// File: rtl/shift_reg_pkg.sv
// Shared mode encoding for the universal shift register.
// Codes 110/111 are left unnamed; the decoder treats them as hold.
package shift_reg_pkg;

   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
   localparam logic [MODE_W-1:0] MODE_ROR  = 3'b011;
   localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'b101;

endpackage

// File: rtl/shift_frame_cnt.sv
// Frame counter: counts shift steps modulo WIDTH and pulses done for one cycle after each wrap.
// Registered outputs, one-cycle latency. There is no flow control; step is acted on every cycle.
module shift_frame_cnt #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     step,
   input  logic                     clear,
   output logic [$clog2(WIDTH)-1:0] cnt,
   output logic                     done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] r_cnt;
   logic          r_done;

   // Explicit compare against WIDTH-1 so non-power-of-two widths wrap correctly.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (clear) begin
            r_cnt <= '0;
         end else if (step) begin
            if (r_cnt == LAST) begin
               r_cnt  <= '0;
               r_done <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign cnt  = r_cnt;
   assign done = r_done;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift, rotate and parallel load, plus serial taps and a frame counter.
// Operation sampled at an edge is visible just after that edge. There is no flow control; mode is acted on every cycle.
module shift_reg_univ
   import shift_reg_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [MODE_W-1:0]        mode,
   input  logic                     sin,
   input  logic [WIDTH-1:0]         pin,
   output logic [WIDTH-1:0]         pout,
   output logic                     sout_r,
   output logic                     sout_l,
   output logic [$clog2(WIDTH)-1:0] shift_cnt,
   output logic                     frame_done
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_step;
   logic             w_clear;

   always_comb begin
      w_q_nxt = r_q;
      w_step  = 1'b0;
      w_clear = 1'b0;
      case (mode)
         MODE_SHR: begin
            w_q_nxt = {sin, r_q[WIDTH-1:1]};
            w_step  = 1'b1;
         end
         MODE_SHL: begin
            w_q_nxt = {r_q[WIDTH-2:0], sin};
            w_step  = 1'b1;
         end
         MODE_ROR: begin
            w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
            w_step  = 1'b1;
         end
         MODE_ROL: begin
            w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            w_step  = 1'b1;
         end
         MODE_LOAD: begin
            w_q_nxt = pin;
            w_clear = 1'b1;
         end
         default: begin
            w_q_nxt = r_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q <= RESET_VAL;
      end else begin
         r_q <= w_q_nxt;
      end
   end

   shift_frame_cnt #(
      .WIDTH (WIDTH)
   ) u_frame_cnt (
      .clk   (clk),
      .reset (reset),
      .step  (w_step),
      .clear (w_clear),
      .cnt   (shift_cnt),
      .done  (frame_done)
   );

   assign pout   = r_q;
   assign sout_r = r_q[0];
   assign sout_l = r_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ at WIDTH=8, RESET_VAL=8'hA5.
module tb_shift_reg_univ;
   import shift_reg_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [2:0]   mode = MODE_HOLD;
   logic         sin = 1'b0;
   logic [W-1:0] pin = '0;
   logic [W-1:0] pout;
   logic         sout_r;
   logic         sout_l;
   logic [2:0]   shift_cnt;
   logic         frame_done;

   int n_chk  = 0;
   int n_pass = 0;

   shift_reg_univ #(
      .WIDTH     (W),
      .RESET_VAL (8'hA5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mode       (mode),
      .sin        (sin),
      .pin        (pin),
      .pout       (pout),
      .sout_r     (sout_r),
      .sout_l     (sout_l),
      .shift_cnt  (shift_cnt),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Drive one operation, let it take effect at the next edge, sample 1 time unit later.
   task automatic op(input logic [2:0] m, input logic s, input logic [W-1:0] p);
      mode = m;
      sin  = s;
      pin  = p;
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0] shr_q   [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
   logic         shr_so  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic         shl_sin [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [W-1:0] shl_q   [8] = '{8'h01, 8'h03, 8'h06, 8'h0D, 8'h1A, 8'h34, 8'h69, 8'hD3};
   logic [W-1:0] rot_q   [6] = '{8'h02, 8'h04, 8'h08, 8'h04, 8'h02, 8'h01};
   logic [W-1:0] pre_q   [5] = '{8'h78, 8'h3C, 8'h1E, 8'h0F, 8'h07};
   logic [2:0]   hold_m  [4] = '{3'b000, 3'b110, 3'b111, 3'b000};
   logic [W-1:0] post_q  [3] = '{8'h83, 8'hC1, 8'hE0};
   logic [W-1:0] mid_q   [5] = '{8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07};
   logic [W-1:0] rst_q   [8] = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};

   initial begin
      // Reset held for two edges
      reset = 1'b0;
      op(MODE_LOAD, 1'b1, 8'h3C);
      op(MODE_LOAD, 1'b1, 8'h3C);
      chk("rst_pout", 64'(pout), 64'hA5);
      chk("rst_sout_r", 64'(sout_r), 64'd1);
      chk("rst_sout_l", 64'(sout_l), 64'd1);
      chk("rst_cnt", 64'(shift_cnt), 64'd0);
      chk("rst_done", 64'(frame_done), 64'd0);
      reset = 1'b1;

      // Load then serialise right
      op(MODE_LOAD, 1'b0, 8'h81);
      chk("ld_pout", 64'(pout), 64'h81);
      chk("ld_cnt", 64'(shift_cnt), 64'd0);
      for (int i = 0; i < 8; i++) begin
         chk("shr_sout_r_pre", 64'(sout_r), 64'(shr_so[i]));
         op(MODE_SHR, 1'b0, 8'hFF);
         chk("shr_pout", 64'(pout), 64'(shr_q[i]));
         chk("shr_cnt", 64'(shift_cnt), 64'((i + 1) % 8));
         chk("shr_done", 64'(frame_done), (i == 7) ? 64'd1 : 64'd0);
      end

      // LOAD in the cycle after a wrap: done still high now, cleared after the load edge
      chk("wrap_ld_done_pre", 64'(frame_done), 64'd1);
      op(MODE_LOAD, 1'b0, 8'h00);
      chk("wrap_ld_pout", 64'(pout), 64'h00);
      chk("wrap_ld_done", 64'(frame_done), 64'd0);

      // Deserialise left
      for (int i = 0; i < 8; i++) begin
         op(MODE_SHL, shl_sin[i], 8'hFF);
         chk("shl_pout", 64'(pout), 64'(shl_q[i]));
         chk("shl_done", 64'(frame_done), (i == 7) ? 64'd1 : 64'd0);
      end
      op(MODE_SHL, 1'b0, 8'hFF);
      chk("shl9_pout", 64'(pout), 64'hA6);
      chk("shl9_cnt", 64'(shift_cnt), 64'd1);
      chk("shl9_done", 64'(frame_done), 64'd0);
      chk("shl9_sout_l", 64'(sout_l), 64'd1);

      // Rotates ignore sin
      op(MODE_LOAD, 1'b1, 8'h01);
      for (int i = 0; i < 6; i++) begin
         op((i < 3) ? MODE_ROL : MODE_ROR, 1'b1, 8'hFF);
         chk("rot_pout", 64'(pout), 64'(rot_q[i]));
         chk("rot_done", 64'(frame_done), 64'd0);
      end
      chk("rot_cnt", 64'(shift_cnt), 64'd6);

      // Hold and reserved modes freeze state
      op(MODE_LOAD, 1'b0, 8'hF0);
      for (int i = 0; i < 5; i++) begin
         op(MODE_SHR, 1'b0, 8'hFF);
         chk("pre_pout", 64'(pout), 64'(pre_q[i]));
      end
      for (int i = 0; i < 4; i++) begin
         op(hold_m[i], 1'b1, 8'hAA);
         chk("hold_pout", 64'(pout), 64'h07);
         chk("hold_cnt", 64'(shift_cnt), 64'd5);
         chk("hold_done", 64'(frame_done), 64'd0);
      end
      for (int i = 0; i < 3; i++) begin
         op(MODE_SHR, 1'b1, 8'hFF);
         chk("post_pout", 64'(pout), 64'(post_q[i]));
         chk("post_done", 64'(frame_done), (i == 2) ? 64'd1 : 64'd0);
      end
      chk("post_cnt", 64'(shift_cnt), 64'd0);

      // Reset mid-frame beats LOAD and discards the partial count
      for (int i = 0; i < 5; i++) begin
         op(MODE_SHR, 1'b0, 8'hFF);
         chk("mid_pout", 64'(pout), 64'(mid_q[i]));
      end
      chk("mid_cnt", 64'(shift_cnt), 64'd5);
      reset = 1'b0;
      op(MODE_LOAD, 1'b0, 8'h55);
      reset = 1'b1;
      chk("mrst_pout", 64'(pout), 64'hA5);
      chk("mrst_cnt", 64'(shift_cnt), 64'd0);
      chk("mrst_done", 64'(frame_done), 64'd0);
      for (int i = 0; i < 8; i++) begin
         op(MODE_SHR, 1'b0, 8'hFF);
         chk("rshr_pout", 64'(pout), 64'(rst_q[i]));
         chk("rshr_done", 64'(frame_done), (i == 7) ? 64'd1 : 64'd0);
      end
      op(MODE_HOLD, 1'b0, 8'h00);
      chk("final_done_fall", 64'(frame_done), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
